// File: rtl/ssd_scan_decoder.sv
// Snoops multiplexed seven-segment anode/segment lines and rebuilds the 4-digit hex value shown,
// with glitch rejection, illegal-pattern flags, frame completion pulses and a staleness timeout.
module ssd_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] value,
    output logic [3:0]  digit_valid,
    output logic [3:0]  digit_blank,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic        stale
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [10:0]   samp;
    logic [10:0]   samp_prev;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    seen;

    logic [3:0] an_s;
    logic [6:0] seg_s;
    logic       same;
    logic       stable_hit;
    logic       capture;
    logic [3:0] sel;
    logic       legal;
    logic       blank;
    logic [3:0] nib;
    logic [3:0] seen_next;

    assign an_s       = samp[10:7];
    assign seg_s      = samp[6:0];
    assign same       = (samp == samp_prev);
    // The counter only passes through STABLE_CYCLES-1 once per stable run, so this fires once.
    assign stable_hit = same && (stab_cnt == SW'(STABLE_CYCLES - 1));
    assign capture    = stable_hit && (sel != 4'b0000);
    assign blank      = (seg_s == 7'h7F);
    assign seen_next  = seen | sel;

    always_comb begin
        sel = 4'b0000;
        case (an_s)
            4'b1110: sel = 4'b0001;
            4'b1101: sel = 4'b0010;
            4'b1011: sel = 4'b0100;
            4'b0111: sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
    end

    always_comb begin
        legal = 1'b1;
        nib   = 4'h0;
        case (seg_s)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            samp        <= '0;
            samp_prev   <= '0;
            stab_cnt    <= '0;
            tmo_cnt     <= '0;
            seen        <= '0;
            value       <= '0;
            digit_valid <= '0;
            digit_blank <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            stale       <= 1'b0;
        end else begin
            samp        <= {an, seg};
            samp_prev   <= samp;
            frame_valid <= 1'b0;
            if (!same)
                stab_cnt <= '0;
            else if (stab_cnt != SW'(STABLE_CYCLES))
                stab_cnt <= stab_cnt + SW'(1);

            if (capture) begin
                tmo_cnt <= '0;
                stale   <= 1'b0;
                if (legal) begin
                    digit_valid <= digit_valid | sel;
                    digit_blank <= digit_blank & ~sel;
                    digit_err   <= digit_err & ~sel;
                    for (int i = 0; i < 4; i++)
                        if (sel[i]) value[4*i +: 4] <= nib;
                end else if (blank) begin
                    digit_blank <= digit_blank | sel;
                    digit_valid <= digit_valid & ~sel;
                end else begin
                    digit_err   <= digit_err | sel;
                    digit_valid <= digit_valid & ~sel;
                end
                if (seen_next == 4'hF) begin
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= seen_next;
                end
            end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
                // Saturate at the terminal count so the timeout fires only once per idle stretch.
                tmo_cnt <= tmo_cnt + TW'(1);
                if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    stale       <= 1'b1;
                    digit_valid <= '0;
                    seen        <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Randomized and directed bench for ssd_scan_decoder against a run-length based reference model.
module tb_ssd_scan_decoder;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] value;
    logic [3:0]  digit_valid, digit_blank, digit_err;
    logic        frame_valid, stale;

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // reference model state
    logic [3:0]  m_nib [4];
    logic [3:0]  m_valid, m_blank, m_err, m_seen;
    logic        m_frame, m_stale;
    int          m_since_cap;
    logic [11:0] m_last;
    int          m_run;
    logic        m_pend;
    logic [10:0] m_pend_pat;

    ssd_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .an(an), .seg(seg), .value(value),
        .digit_valid(digit_valid), .digit_blank(digit_blank), .digit_err(digit_err),
        .frame_valid(frame_valid), .stale(stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_valid = 0; m_blank = 0; m_err = 0; m_seen = 0;
        m_frame = 0; m_stale = 0; m_since_cap = 0;
        m_last = 12'h800; m_run = 0; m_pend = 0; m_pend_pat = 0;
    endtask

    // One rising edge: apply the capture decided from pin history, then log the pins just sampled.
    task automatic model_edge();
        logic       cap;
        logic [10:0] pat;
        int          zeros, idx, code;
        if (reset) begin
            model_reset();
            return;
        end
        cap = m_pend;
        pat = m_pend_pat;
        if ({1'b0, an, seg} == m_last) m_run++;
        else begin
            m_last = {1'b0, an, seg};
            m_run  = 1;
        end
        m_pend     = (m_run == STABLE + 1);
        m_pend_pat = m_last[10:0];
        m_frame    = 0;
        zeros = 0; idx = 0;
        for (int i = 0; i < 4; i++)
            if (!pat[7+i]) begin zeros++; idx = i; end
        if (cap && zeros == 1) begin
            m_since_cap = 0;
            m_stale     = 0;
            code = -1;
            for (int j = 0; j < 16; j++) if (seg_tab[j] == pat[6:0]) code = j;
            if (code >= 0) begin
                m_nib[idx] = 4'(code);
                m_valid[idx] = 1; m_blank[idx] = 0; m_err[idx] = 0;
            end else if (pat[6:0] == 7'h7F) begin
                m_blank[idx] = 1; m_valid[idx] = 0;
            end else begin
                m_err[idx] = 1; m_valid[idx] = 0;
            end
            m_seen[idx] = 1;
            if (m_seen == 4'hF) begin
                m_frame = 1;
                m_seen  = 0;
            end
        end else if (m_since_cap < TIMEOUT) begin
            m_since_cap++;
            if (m_since_cap == TIMEOUT) begin
                m_stale = 1; m_valid = 0; m_seen = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (frame_valid === 1'b1) frames_seen++;
        chk("value", 32'(value), 32'({m_nib[3], m_nib[2], m_nib[1], m_nib[0]}));
        chk("digit_valid", 32'(digit_valid), 32'(m_valid));
        chk("digit_blank", 32'(digit_blank), 32'(m_blank));
        chk("digit_err", 32'(digit_err), 32'(m_err));
        chk("frame_valid", 32'(frame_valid), 32'(m_frame));
        chk("stale", 32'(stale), 32'(m_stale));
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an = a; seg = s;
        repeat (n) step();
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] s3, input int hold);
        drive(4'b1110, s0, hold);
        drive(4'b1101, s1, hold);
        drive(4'b1011, s2, hold);
        drive(4'b0111, s3, hold);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        int r, a_idx;
        logic [3:0] a;
        logic [6:0] s;
        model_reset();
        do_reset(3);
        chk("reset_value", 32'(value), 32'h0);
        chk("reset_flags", 32'({digit_valid, digit_blank, digit_err, frame_valid, stale}), 32'h0);

        // two scans of 1234, one frame pulse each
        scan(7'h19, 7'h30, 7'h24, 7'h79, 8);
        frames_seen = 0;
        scan(7'h19, 7'h30, 7'h24, 7'h79, 8);
        drive(4'hF, 7'h7F, 2);
        chk("scan_value", 32'(value), 32'h1234);
        chk("scan_valid", 32'(digit_valid), 32'hF);
        chk("scan_frames", 32'(frames_seen), 32'd1);

        // glitch rejection: 3 and 4 clocks too short, 5 captures once
        drive(4'b1110, 7'h40, 3);
        drive(4'hF, 7'h7F, 2);
        drive(4'b1110, 7'h40, 4);
        drive(4'hF, 7'h7F, 2);
        chk("short_hold", 32'(value), 32'h1234);
        drive(4'b1110, 7'h40, 5);
        drive(4'hF, 7'h7F, 1);
        chk("hold5_value", 32'(value), 32'h1230);

        // two anodes low: ignored
        drive(4'b1100, 7'h40, 20);
        chk("multi_an", 32'(value), 32'h1230);

        // blank and illegal digits
        frames_seen = 0;
        scan(7'h79, 7'h24, 7'h7F, 7'h55, 8);
        drive(4'hF, 7'h7F, 1);
        chk("blank_mask", 32'(digit_blank), 32'h4);
        chk("err_mask", 32'(digit_err), 32'h8);
        chk("valid_mask", 32'(digit_valid), 32'h3);
        chk("err_frames", 32'(frames_seen), 32'd1);

        // idle until timeout, then resume
        drive(4'hF, 7'h7F, TIMEOUT + 10);
        chk("stale_set", 32'(stale), 32'h1);
        chk("stale_valid", 32'(digit_valid), 32'h0);
        scan(7'h19, 7'h30, 7'h24, 7'h79, 8);
        chk("stale_clear", 32'(stale), 32'h0);

        // reset mid-frame, then a full scan gives exactly one frame
        drive(4'b1110, 7'h40, 8);
        drive(4'b1101, 7'h40, 8);
        do_reset(1);
        chk("midreset", 32'({value, digit_valid, digit_blank, digit_err, frame_valid, stale}), 32'h0);
        frames_seen = 0;
        scan(7'h12, 7'h02, 7'h78, 7'h00, 8);
        chk("post_reset_frames", 32'(frames_seen), 32'd1);

        // randomized scanning
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 80) begin
                a_idx = $urandom_range(0, 3);
                a = 4'hF;
                a[a_idx] = 1'b0;
            end else begin
                a = 4'($urandom_range(0, 15));
            end
            r = $urandom_range(0, 99);
            if (r < 60) s = seg_tab[$urandom_range(0, 15)];
            else if (r < 75) s = 7'h7F;
            else s = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 2));
            else if ($urandom_range(0, 79) == 0) drive(4'hF, 7'h7F, $urandom_range(40, 60));
            else drive(a, s, $urandom_range(1, 9));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
